// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit.
// funct3 codes, FSM state encoding and byte-enable patterns.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response bundle and data-memory bus bundle.
// The load/store unit is the slave of the core and the master of memory.
interface lsu_core_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, stall
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, stall
    );
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Access checking, store lane steering and load extract/extend.
// Purely combinational; request side and load side are independent.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        err,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic        mis;
    logic        ill;
    logic [31:0] sh;

    always_comb begin
        be    = BE_WORD;
        wdata = req_wdata;
        mis   = 1'b0;
        ill   = 1'b0;
        if (req_we) begin
            case (req_funct3)
                F3_SB: begin
                    be    = BE_BYTE << req_off;
                    wdata = {4{req_wdata[7:0]}};
                end
                F3_SH: begin
                    be    = BE_HALF << req_off;
                    wdata = {2{req_wdata[15:0]}};
                    mis   = req_off[0];
                end
                F3_SW:   mis = |req_off;
                default: ill = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                F3_LB, F3_LBU: mis = 1'b0;
                F3_LH, F3_LHU: mis = req_off[0];
                F3_LW:         mis = |req_off;
                default:       ill = 1'b1;
            endcase
        end
        err = mis | ill;
    end

    always_comb begin
        sh      = rdata >> {ld_off, 3'b000};
        ld_data = sh;
        case (ld_funct3)
            F3_LB:   ld_data = {{24{sh[7]}}, sh[7:0]};
            F3_LH:   ld_data = {{16{sh[15]}}, sh[15:0]};
            F3_LBU:  ld_data = {24'h0, sh[7:0]};
            F3_LHU:  ld_data = {16'h0, sh[15:0]};
            default: ld_data = sh;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Execute/memory-stage load/store unit: one req/ack bus transaction
// per request, stalling the core while it is outstanding.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    lsu_core_if.slave   core,
    lsu_mem_if.master   mem
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TMAX =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t        state;
    state_t        state_n;
    logic [1:0]    off;
    logic [2:0]    f3;
    logic [CW-1:0] cnt;
    logic          tmo;
    logic [3:0]    a_be;
    logic [31:0]   a_wdata;
    logic          a_err;
    logic [31:0]   ld_data;
    logic          ready;
    logic          stall;
    logic          mreq;
    logic          rvalid;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    lsu_align u_align (
        .req_we     (core.req_we),
        .req_funct3 (core.req_funct3),
        .req_off    (core.req_addr[1:0]),
        .req_wdata  (core.req_wdata),
        .be         (a_be),
        .wdata      (a_wdata),
        .err        (a_err),
        .ld_funct3  (f3),
        .ld_off     (off),
        .rdata      (mem.mem_rdata),
        .ld_data    (ld_data)
    );

    // Reaching the last allowed cycle without an ack ends the access.
    assign tmo = (TIMEOUT_CYCLES > 0) && (cnt == TMAX);

    always_comb begin
        state_n = state;
        ready   = 1'b0;
        stall   = 1'b0;
        mreq    = 1'b0;
        rvalid  = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                stall = core.req_valid;
                if (core.req_valid) state_n = a_err ? DONE : REQ;
            end
            REQ: begin
                mreq  = 1'b1;
                stall = 1'b1;
                if (mem.mem_ack || tmo) state_n = DONE;
            end
            DONE: begin
                rvalid  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            off     <= 2'b0;
            f3      <= 3'b0;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (core.req_valid) begin
                    if (a_err) begin
                        err_q   <= 1'b1;
                        rdata_q <= 32'h0;
                    end else begin
                        we_q    <= core.req_we;
                        addr_q  <= {core.req_addr[31:2], 2'b00};
                        be_q    <= core.req_we ? a_be : BE_WORD;
                        wdata_q <= a_wdata;
                        off     <= core.req_addr[1:0];
                        f3      <= core.req_funct3;
                        cnt     <= '0;
                    end
                end
                REQ: begin
                    // Ack beats a simultaneous timeout.
                    if (mem.mem_ack) begin
                        err_q   <= 1'b0;
                        rdata_q <= we_q ? 32'h0 : ld_data;
                    end else if (tmo) begin
                        err_q   <= 1'b1;
                        rdata_q <= 32'h0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign core.req_ready  = ready;
    assign core.stall      = stall;
    assign core.resp_valid = rvalid;
    assign core.resp_rdata = rdata_q;
    assign core.resp_err   = err_q;
    assign mem.mem_req     = mreq;
    assign mem.mem_we      = we_q;
    assign mem.mem_addr    = addr_q;
    assign mem.mem_be      = be_q;
    assign mem.mem_wdata   = wdata_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Execute/memory-stage load-store unit, directly downstream of the ALU: it takes the ALU result as the effective address, plus rs2 store data and funct3, and runs one data-memory transaction over a req/ack bus. It generates byte enables and lane-replicated store data, extracts and extends load data, and detects misaligned or illegal accesses. While the transaction is outstanding it holds the single-cycle core with a stall.

## Interface
- TIMEOUT_CYCLES, 255: consecutive unacknowledged request cycles before a bus-timeout error; 0 disables the timeout.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  core presents a load/store this cycle
- req_ready  out  1  unit is idle and can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  32  effective address (ALU result)
- req_wdata  in  32  store data (rs2)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid: misaligned, illegal funct3, or timeout
- stall  out  1  core must hold PC and request
- mem_req  out  1  bus request, held until ack
- mem_we  out  1  bus write
- mem_addr  out  32  word-aligned address ({req_addr[31:2],2'b00})
- mem_be  out  4  byte enables (write strobes; all 1s on reads)
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  bus completion; mem_rdata valid in the same cycle
- mem_rdata  in  32  read word

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: req_ready=1. On req_valid:
  - Illegal or misaligned request: go to DONE with err=1. No bus access.
  - Otherwise: register mem_addr, mem_be, mem_wdata, mem_we, the byte offset and funct3, then go to REQ.
- REQ: mem_req=1 and all mem_* outputs stable.
  - mem_ack: capture the extracted load data and go to DONE.
  - Timeout: go to DONE with err=1.
- DONE: resp_valid=1 for exactly one cycle, then return to IDLE.
- funct3 decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Loads with 011, 110 or 111 are illegal.
  - Stores: 000 SB, 001 SH, 010 SW. Stores with any other code are illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
- Byte enables:
  - Byte: 4'b0001<<addr[1:0].
  - Half: 4'b0011<<addr[1:0].
  - Word: 4'b1111.
  - Loads: 4'b1111.
- Store data: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
- Load data:
  - Shift mem_rdata right by 8*offset.
  - LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW passes through.
- stall = (IDLE & req_valid) | REQ. stall is 0 in DONE, so the core advances on the same edge it writes back resp_rdata.
- mem_ack outside REQ is ignored.

## Timing
- Accept in cycle N. mem_req=1 from N+1.
- Ack in cycle k≥N+1 → resp_valid in k+1. Best-case latency: request to response in 2 cycles.
- Error path: accept at N → resp_valid/resp_err at N+1. mem_req is never asserted.
- Timeout:
  - Counter is cleared on entry to REQ and increments every REQ cycle without ack.
  - At TIMEOUT_CYCLES unacked cycles, mem_req drops the next cycle and resp_err pulses with it.
  - If ack arrives in the same cycle the timeout is reached, ack wins and there is no error.
- Back-to-back: the next request is accepted in the IDLE cycle after DONE. There is no overlap.
- Reset values (rst_n low at an edge):
  - State IDLE.
  - mem_req, mem_we, resp_valid, resp_err = 0; mem_addr, mem_be, mem_wdata, resp_rdata = 0.
  - req_ready=1 from the first cycle after reset.
- Reset mid-operation: an outstanding REQ is abandoned. mem_req drops at the reset edge, no response is produced, and a late ack is ignored.

## Structure
- lsu_pkg holds:
  - funct3 localparams (LB/LH/LW/LBU/LHU/SB/SH/SW)
  - the state enum
  - byte-enable constants
- Sub-module lsu_align (combinational): misalign/illegal check, be/wdata generation, load extract/extend.
- load_store_unit holds the FSM, registers and timeout counter.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF, ack at N+1 → mem_be=1111, mem_wdata=0xDEADBEEF, mem_addr=0x100; resp_valid at N+2, err=0, rdata=0.
- SB addr 0x103, wdata 0x000000A5 → mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- mem_rdata=0x80FF7F01: LB @0x101 → 0x0000007F; LB @0x102 → 0xFFFFFFFF; LH @0x102 → 0xFFFF80FF; LHU @0x102 → 0x000080FF.
- LW @0x102, and LH @0x101 → resp_err pulses at N+1, mem_req stays 0; stall high only in cycle N.
- TIMEOUT_CYCLES=4, no ack → mem_req high 4 cycles, then resp_err; repeat with ack on the 4th cycle → no error, valid data.
- rst_n low on the 2nd REQ cycle → mem_req=0 the next cycle, no resp_valid, req_ready=1; a stray ack after reset has no effect.
